// File: rtl/mul_dsp_pkg.sv
// Shared types and arithmetic helpers for the streaming DSP multiplier.
// Post-processing is computed on a fixed wide path so one function serves every lane width.
package mul_dsp_pkg;

    localparam int MODE_SHIFT_W = 6;
    localparam int CALC_W       = 64;

    typedef struct packed {
        logic                    signed_m;
        logic                    saturate;
        logic [MODE_SHIFT_W-1:0] shift;
    } mode_t;

    function automatic int shift_w(input int word_width);
        return $clog2(2 * word_width);
    endfunction

    // v is the product already sign/zero-extended to CALC_W, so the rounding add cannot overflow
    function automatic logic [CALC_W-1:0] round_sat(input logic [CALC_W-1:0] v,
                                                    input mode_t             m,
                                                    input int                out_w);
        logic [CALC_W-1:0]        sum;
        logic signed [CALC_W-1:0] s_sum;
        logic [CALC_W-1:0]        r;
        logic [CALC_W-1:0]        hi;
        logic [CALC_W-1:0]        lo;
        if (m.shift != MODE_SHIFT_W'(0)) begin
            sum = v + (64'd1 << (m.shift - MODE_SHIFT_W'(1)));
        end else begin
            sum = v;
        end
        s_sum = sum;
        if (m.signed_m) begin
            r = s_sum >>> m.shift;
        end else begin
            r = sum >> m.shift;
        end
        hi = '0;
        lo = '0;
        if (m.saturate && m.signed_m) begin
            hi = (64'd1 << (out_w - 1)) - 64'd1;
            lo = ~hi;
            if ($signed(r) > $signed(hi)) begin
                r = hi;
            end else if ($signed(r) < $signed(lo)) begin
                r = lo;
            end
        end else if (m.saturate) begin
            hi = (64'd1 << out_w) - 64'd1;
            if (r > hi) begin
                r = hi;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_dsp_lane.sv
// One multiplier lane: operand pipeline, full-width product register and rounded/saturated output register.
module mul_dsp_lane
    import mul_dsp_pkg::*;
#(
    parameter int WORD_WIDTH  = 8,
    parameter int PIPE_STAGES = 3,
    parameter int OUT_WIDTH   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_load,
    input  logic [WORD_WIDTH-1:0] i_a,
    input  logic [WORD_WIDTH-1:0] i_b,
    input  logic                  i_prod_signed,
    input  mode_t                 i_post_mode,
    output logic [OUT_WIDTH-1:0]  o_prod
);

    localparam int PW = 2 * WORD_WIDTH;

    logic [WORD_WIDTH-1:0] w_a_pre;
    logic [WORD_WIDTH-1:0] w_b_pre;
    logic [PW-1:0]         w_a_ext;
    logic [PW-1:0]         w_b_ext;
    logic [PW-1:0]         w_prod;
    logic [CALC_W-1:0]     w_prod_ext;
    logic [PW-1:0]         r_prod;
    logic [OUT_WIDTH-1:0]  r_out;

    generate
        if (PIPE_STAGES > 1) begin : g_opnd
            logic [WORD_WIDTH-1:0] r_a [PIPE_STAGES-1];
            logic [WORD_WIDTH-1:0] r_b [PIPE_STAGES-1];
            // Operand delay line, data only (no reset)
            always_ff @(posedge i_clk) begin
                if (i_en) begin
                    r_a[0] <= i_a;
                    r_b[0] <= i_b;
                    for (int s = 1; s < PIPE_STAGES - 1; s++) begin
                        r_a[s] <= r_a[s-1];
                        r_b[s] <= r_b[s-1];
                    end
                end
            end
            assign w_a_pre = r_a[PIPE_STAGES-2];
            assign w_b_pre = r_b[PIPE_STAGES-2];
        end else begin : g_no_opnd
            assign w_a_pre = i_a;
            assign w_b_pre = i_b;
        end
    endgenerate

    // Extending both operands to full width makes one multiplier serve signed and unsigned beats
    assign w_a_ext    = {{WORD_WIDTH{i_prod_signed & w_a_pre[WORD_WIDTH-1]}}, w_a_pre};
    assign w_b_ext    = {{WORD_WIDTH{i_prod_signed & w_b_pre[WORD_WIDTH-1]}}, w_b_pre};
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = {{(CALC_W-PW){i_post_mode.signed_m & r_prod[PW-1]}}, r_prod};

    // Product register (DSP output register)
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_prod <= w_prod;
        end
    end

    // Output register loads only on a valid beat so an idle pipe keeps the last result
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out <= '0;
        end else if (i_load) begin
            r_out <= OUT_WIDTH'(round_sat(w_prod_ext, i_post_mode, OUT_WIDTH));
        end
    end

    assign o_prod = r_out;

endmodule

// File: rtl/mul_dsp_stream.sv
// Streaming NUM_TERMS-lane multiplier with valid/ready backpressure, rounding shift and saturation.
module mul_dsp_stream
    import mul_dsp_pkg::*;
#(
    parameter int WORD_WIDTH  = 8,
    parameter int NUM_TERMS   = 72,
    parameter int PIPE_STAGES = 3,
    parameter int OUT_WIDTH   = 8,
    localparam int SHIFT_W    = shift_w(WORD_WIDTH)
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [WORD_WIDTH*NUM_TERMS-1:0] i_terms_a,
    input  logic [WORD_WIDTH*NUM_TERMS-1:0] i_terms_b,
    input  logic                            i_signed,
    input  logic                            i_saturate,
    input  logic [SHIFT_W-1:0]              i_shift,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [OUT_WIDTH*NUM_TERMS-1:0]  o_products,
    output logic                            o_busy
);

    generate
        if (WORD_WIDTH < 2 || WORD_WIDTH > 31 || NUM_TERMS < 1 || PIPE_STAGES < 1 ||
            OUT_WIDTH < 1 || OUT_WIDTH > 2 * WORD_WIDTH) begin : g_param_err
            $error("mul_dsp_stream: illegal parameter combination");
        end
    endgenerate

    logic                   w_en;
    logic [PIPE_STAGES-1:0] w_vld_nxt;
    logic                   w_out_vld_nxt;
    mode_t                  w_mode_in;
    mode_t                  w_mode_pre;
    logic [PIPE_STAGES-1:0] r_vld;
    logic                   r_out_vld;
    logic                   r_busy;
    mode_t                  r_mode [PIPE_STAGES];

    assign w_en    = !(r_out_vld && !i_ready);
    assign o_ready = w_en;
    assign o_valid = r_out_vld;
    assign o_busy  = r_busy;

    // Pack the per-beat mode so it travels alongside its data
    always_comb begin
        w_mode_in          = '0;
        w_mode_in.signed_m = i_signed;
        w_mode_in.saturate = i_saturate;
        w_mode_in.shift    = MODE_SHIFT_W'(i_shift);
    end

    // Valid shift register advance; bubbles move exactly like beats
    always_comb begin
        w_vld_nxt     = r_vld;
        w_out_vld_nxt = r_out_vld;
        if (w_en) begin
            w_vld_nxt     = PIPE_STAGES'({r_vld, i_valid});
            w_out_vld_nxt = r_vld[PIPE_STAGES-1];
        end else begin
            w_vld_nxt     = r_vld;
            w_out_vld_nxt = r_out_vld;
        end
    end

    // Control state: valid bits, output valid and busy flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld     <= '0;
            r_out_vld <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_vld     <= w_vld_nxt;
            r_out_vld <= w_out_vld_nxt;
            r_busy    <= (|w_vld_nxt) | w_out_vld_nxt;
        end
    end

    // Mode delay line shared by all lanes
    always_ff @(posedge i_clk) begin
        if (w_en) begin
            r_mode[0] <= w_mode_pre;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                r_mode[s] <= r_mode[s-1];
            end
        end
    end

    generate
        if (PIPE_STAGES > 1) begin : g_mode_pre
            logic [PIPE_STAGES-2:0] w_unused_dummy;
            assign w_unused_dummy = '0;
        end
    endgenerate

    // w_mode_pre is the mode at the product stage's input (aligned with the lane operands)
    generate
        if (PIPE_STAGES > 1) begin : g_mode_sel
            mode_t r_mode_op [PIPE_STAGES-1];
            always_ff @(posedge i_clk) begin
                if (w_en) begin
                    r_mode_op[0] <= w_mode_in;
                    for (int s = 1; s < PIPE_STAGES - 1; s++) begin
                        r_mode_op[s] <= r_mode_op[s-1];
                    end
                end
            end
            assign w_mode_pre = r_mode_op[PIPE_STAGES-2];
        end else begin : g_mode_direct
            assign w_mode_pre = w_mode_in;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TERMS; gi++) begin : g_lane
            mul_dsp_lane #(
                .WORD_WIDTH  (WORD_WIDTH),
                .PIPE_STAGES (PIPE_STAGES),
                .OUT_WIDTH   (OUT_WIDTH)
            ) u_lane (
                .i_clk         (i_clk),
                .i_rst_n       (i_rst_n),
                .i_en          (w_en),
                .i_load        (w_en & r_vld[PIPE_STAGES-1]),
                .i_a           (i_terms_a[WORD_WIDTH*gi +: WORD_WIDTH]),
                .i_b           (i_terms_b[WORD_WIDTH*gi +: WORD_WIDTH]),
                .i_prod_signed (w_mode_pre.signed_m),
                .i_post_mode   (r_mode[0]),
                .o_prod        (o_products[OUT_WIDTH*gi +: OUT_WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_mul_dsp_stream.sv
// Scoreboard bench for mul_dsp_stream: directed beats push expected lane results, a monitor pops on each output handshake.
module tb_mul_dsp_stream;

    localparam int WW  = 8;
    localparam int NT  = 72;
    localparam int PS  = 3;
    localparam int OW  = 8;
    localparam int SW  = 4;
    localparam int VW  = WW * NT;
    localparam int OVW = OW * NT;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_valid = 1'b0;
    logic           i_signed = 1'b0;
    logic           i_saturate = 1'b0;
    logic           i_ready = 1'b1;
    logic [VW-1:0]  terms_a = '0;
    logic [VW-1:0]  terms_b = '0;
    logic [SW-1:0]  shift = '0;
    logic           o_ready;
    logic           o_valid;
    logic           o_busy;
    logic [OVW-1:0] o_products;

    typedef struct {
        logic [OW-1:0] val;
        int            acc_cyc;
        bit            chk_lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    mul_dsp_stream #(
        .WORD_WIDTH  (WW),
        .NUM_TERMS   (NT),
        .PIPE_STAGES (PS),
        .OUT_WIDTH   (OW)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_terms_a  (terms_a),
        .i_terms_b  (terms_b),
        .i_signed   (i_signed),
        .i_saturate (i_saturate),
        .i_shift    (shift),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_products (o_products),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [VW-1:0] lanes_in(input logic [WW-1:0] v);
        logic [VW-1:0] r;
        r = '0;
        r[0 +: WW] = v;
        r[WW*(NT-1) +: WW] = v;
        return r;
    endfunction

    function automatic logic [OVW-1:0] lanes_out(input logic [OW-1:0] v);
        logic [OVW-1:0] r;
        r = '0;
        r[0 +: OW] = v;
        r[OW*(NT-1) +: OW] = v;
        return r;
    endfunction

    task automatic check(input string name, input logic [OVW-1:0] act, input logic [OVW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: handshake-driven scoreboard pop plus ready/stall relation every cycle
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            check("o_ready_vs_stall", OVW'(o_ready), OVW'(!(o_valid && !i_ready)));
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_beat: got %0h with empty scoreboard", o_products);
                end else begin
                    e = exp_q.pop_front();
                    check("product", o_products, lanes_out(e.val));
                    if (e.chk_lat) begin
                        check("latency", OVW'(cyc - e.acc_cyc), OVW'(4));
                    end
                end
            end
        end
    end

    task automatic send(input logic [WW-1:0] a, input logic [WW-1:0] b, input logic sgn,
                        input logic sat, input logic [SW-1:0] sh, input logic [OW-1:0] ev, input bit lat);
        exp_t e;
        bit   done;
        done       = 1'b0;
        terms_a    = lanes_in(a);
        terms_b    = lanes_in(b);
        i_signed   = sgn;
        i_saturate = sat;
        shift      = sh;
        i_valid    = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (o_ready) begin
                e.val     = ev;
                e.acc_cyc = cyc;
                e.chk_lat = lat;
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: beat a=%0h b=%0h never accepted", a, b);
        end
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 200 && (exp_q.size() != 0 || o_busy); t++) begin
            @(posedge clk);
            #1;
        end
        check({name, "_queue_empty"}, OVW'(exp_q.size()), OVW'(0));
        check({name, "_busy_idle"}, OVW'(o_busy), OVW'(1'b0));
    endtask

    initial begin
        #2;
        check("rst_o_valid", OVW'(o_valid), OVW'(1'b0));
        check("rst_o_busy", OVW'(o_busy), OVW'(1'b0));
        check("rst_o_products", o_products, OVW'(0));
        check("rst_o_ready", OVW'(o_ready), OVW'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(8'd200, 8'd3,   1'b0, 1'b0, 4'd0, 8'h58, 1'b1);
        send(8'h80,  8'h80,  1'b1, 1'b1, 4'd0, 8'h7F, 1'b1);
        send(8'h80,  8'h7F,  1'b1, 1'b1, 4'd0, 8'h80, 1'b1);
        send(8'hF9,  8'd5,   1'b1, 1'b0, 4'd4, 8'hFE, 1'b1);
        send(8'hFF,  8'hFF,  1'b0, 1'b0, 4'd8, 8'hFE, 1'b1);
        send(8'hFF,  8'hFF,  1'b0, 1'b1, 4'd0, 8'hFF, 1'b1);
        drain("arith");

        for (int k = 0; k < 6; k++) begin
            send(8'hFF, 8'h02, (k % 2 == 0), 1'b1, 4'd0, (k % 2 == 0) ? 8'hFE : 8'hFF, 1'b1);
        end
        drain("mode_alt");

        fork
            begin
                for (int k = 1; k <= 10; k++) begin
                    send(8'(k), 8'(k), 1'b0, 1'b0, 4'd0, 8'(k * k), 1'b0);
                end
            end
            begin
                repeat (6) @(posedge clk);
                #1 i_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 i_ready = 1'b1;
            end
        join
        drain("backpressure");

        i_ready = 1'b0;
        send(8'd1, 8'd1, 1'b0, 1'b0, 4'd0, 8'd1, 1'b0);
        send(8'd2, 8'd2, 1'b0, 1'b0, 4'd0, 8'd4, 1'b0);
        send(8'd3, 8'd3, 1'b0, 1'b0, 4'd0, 8'd9, 1'b0);
        for (int t = 0; t < 20 && !o_valid; t++) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_valid", OVW'(o_valid), OVW'(1'b1));
        check("pre_reset_busy", OVW'(o_busy), OVW'(1'b1));
        rst_n = 1'b0;
        #1;
        check("mid_reset_valid", OVW'(o_valid), OVW'(1'b0));
        check("mid_reset_busy", OVW'(o_busy), OVW'(1'b0));
        exp_q.delete();
        i_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'd2, 8'd3, 1'b0, 1'b0, 4'd0, 8'd6, 1'b1);
        drain("post_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mul_dsp_stream.md
Name: mul_dsp_stream

Overview:
Streaming successor to the fixed 3-stage DSP multiplier array. It multiplies NUM_TERMS lane pairs, with configurable pipeline depth and a valid/ready handshake with backpressure. Per-beat signed/unsigned mode, rounding right-shift and optional saturation reduce each 2*WORD_WIDTH product to OUT_WIDTH. It sits between the window/weight fetch logic and the adder tree of the conv datapath.

Parameters:
WORD_WIDTH, 8, operand width per lane (>=2)
NUM_TERMS, 72, number of parallel lanes (>=1)
PIPE_STAGES, 3, DSP pipeline depth including the product register (>=1)
OUT_WIDTH, 8, output width per lane (1..2*WORD_WIDTH)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  input beat valid
o_ready  out  1  block can accept a beat this cycle
i_terms_a  in  WORD_WIDTH*NUM_TERMS  lane operands A; lane i at [WORD_WIDTH*i +: WORD_WIDTH]
i_terms_b  in  WORD_WIDTH*NUM_TERMS  lane operands B
i_signed  in  1  beat mode: 1 = two's complement operands, 0 = unsigned
i_saturate  in  1  beat mode: 1 = clamp to OUT_WIDTH range, 0 = keep low OUT_WIDTH bits
i_shift  in  SHIFT_W  rounding right-shift amount; SHIFT_W = $clog2(2*WORD_WIDTH)
o_valid  out  1  output beat valid
i_ready  in  1  downstream accepts the output beat
o_products  out  OUT_WIDTH*NUM_TERMS  lane results, same lane packing as the inputs
o_busy  out  1  at least one beat in flight or held at the output

Behaviour:
- Reset is asynchronous, active low. Reset values: all stage valid bits 0, o_valid 0, o_products 0, o_busy 0. o_ready is 1 one cycle after reset release. DSP data registers are not reset. Only the valid bits and the output register are reset.
- Acceptance: a beat is accepted when i_valid && o_ready at a rising edge.
- Backpressure: stall = o_valid && !i_ready. o_ready = !stall (combinational from i_ready). On stall, every stage holds its contents through clock enables. There are no drops and no duplicates, and order is preserved.
- Latency: PIPE_STAGES+1 cycles from acceptance to o_valid when there are no stalls. Default latency is 4. Throughput is 1 beat/cycle.
- Pipeline structure:
  - Stages 1..PIPE_STAGES-1 register the A/B operands and mode bits.
  - Stage PIPE_STAGES registers the full 2*WORD_WIDTH product.
  - The post stage registers o_products and o_valid.
  - Mode bits travel with their beat, so a mode change between consecutive beats is legal.
- Arithmetic per lane:
  - p = A*B at 2*WORD_WIDTH bits, sign-extended when i_signed=1.
  - If shift>0: r = (p + (1<<(shift-1))) >>> shift. The shift is arithmetic when signed and logical when unsigned (round half up). The rounding add must not overflow, so compute it in 2*WORD_WIDTH+1 bits.
  - If i_saturate: clamp r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] when signed, or [0, 2^OUT_WIDTH-1] when unsigned.
  - Otherwise the result is r[OUT_WIDTH-1:0].
- Empty pipeline: o_valid=0, o_busy=0, o_products holds its last value.
- Simultaneous accept and output handshake in the same cycle: both happen, and the pipeline advances.
- i_valid=0 cycles insert bubbles. Bubbles are not compressed.
- Reset mid-operation: all in-flight beats are discarded, and o_valid=0 is immediate (asynchronous).
- Elaboration: the block must $error on parameter violations.

Decomposition:
- Package mul_dsp_pkg holds:
  - the SHIFT_W helper function (clog2 of 2*WORD_WIDTH);
  - a packed mode_t struct {signed_m, saturate, shift};
  - the sat/round function on a 2*WORD_WIDTH+1 value.
- Sub-module mul_dsp_lane: one lane's operand pipeline, product register and post stage, with a shared enable input.
- The top module owns the valid shift register, stall/enable generation and o_busy, and instantiates NUM_TERMS lanes via generate.

Test Plan (WORD_WIDTH=8, OUT_WIDTH=8, PIPE_STAGES=3):
1. Unsigned, shift 0, no saturation: A=200, B=3 in lane 0 -> lane 0 = 0x58 (600 truncated), o_valid exactly 4 cycles after acceptance.
2. Signed, saturate, shift 0: A=0x80, B=0x80 (+16384) -> 0x7F. A=0x80, B=0x7F (-16256) -> 0x80.
3. Signed, shift 4, no saturation: A=-7, B=5 (-35) -> (-35+8)>>>4 = 0xFE. Unsigned 255*255 with shift 8 -> 0xFE. Same product with shift 0 and saturate -> 0xFF.
4. Backpressure: stream 10 back-to-back beats (lane values k=1..10, A=k, B=k), i_ready low for 4 cycles mid-stream -> o_ready low exactly while o_valid&&!i_ready, outputs 1,4,...,100 in order, none lost or duplicated.
5. Mode change per beat: alternate signed/unsigned on A=0xFF, B=0x02, shift 0, saturate -> outputs alternate 0xFE (-2) and 0xFF (510 clamped).
6. Reset mid-operation: assert i_rst_n=0 with 3 beats in flight -> o_valid and o_busy 0 immediately. After release, one new beat A=2, B=3 -> single output 6 after 4 cycles, no stale beats.
